// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and the memory-stage state encoding.
package cpu_pkg;
  localparam int DATA_W    = 16;
  localparam int REG_IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;
endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_i,
  output logic [15:0] count_o
);
  logic [15:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 16'd0;
    end else if (inc_i && (count_q != 16'hFFFF)) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign count_o = count_q;
endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues data-memory requests, stalls the front of the pipe until the
// access completes, and builds MEM/WB inputs. Define MEM_FWD_EN to forward WB data into stores.
module mem_stage_ctrl
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 xm_regwrite,
  input  logic                 xm_memread,
  input  logic                 xm_memwrite,
  input  logic                 xm_memtoreg,
  input  logic                 xm_savepc,
  input  logic                 xm_halt,
  input  logic [DATA_W-1:0]    xm_b,
  input  logic [DATA_W-1:0]    xm_aluresult,
  input  logic [DATA_W-1:0]    xm_newpc,
  input  logic [REG_IDX_W-1:0] xm_reg_dest,
  input  logic [REG_IDX_W-1:0] xm_source2,
  input  logic                 wb_regwrite,
  input  logic [REG_IDX_W-1:0] wb_reg_dest,
  input  logic [DATA_W-1:0]    wb_data,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [DATA_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic                 mem_valid,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic                 stall,
  output logic                 mw_regwrite,
  output logic                 mw_halt,
  output logic [REG_IDX_W-1:0] mw_reg_dest,
  output logic [DATA_W-1:0]    mw_wdata,
  output logic [15:0]          stall_cnt
);
  mem_state_t        state_q, state_d, curState;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] storeData;
  logic              memOp;

  assign memOp = xm_memread | xm_memwrite;

`ifdef MEM_FWD_EN
  always_comb begin
    storeData = xm_b;
    if (xm_memwrite && wb_regwrite && (wb_reg_dest == xm_source2) &&
        (wb_reg_dest != '0)) begin
      storeData = wb_data;
    end
  end
`else
  logic unusedWb;
  assign unusedWb  = ^{wb_regwrite, wb_reg_dest, wb_data, xm_source2};
  assign storeData = xm_b;
`endif

  // While reset is held the outputs behave as in IDLE for the inputs currently presented.
  always_comb begin
    curState = rst ? IDLE : state_q;
    state_d  = curState;
    hold_d   = hold_q;
    stall    = 1'b0;
    mem_req  = 1'b0;
    unique case (curState)
      IDLE: begin
        stall   = memOp;
        mem_req = memOp;
        state_d = memOp ? BUSY : IDLE;
      end
      BUSY: begin
        stall = 1'b1;
        if (mem_valid) begin
          hold_d  = mem_rdata;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  assign mem_we    = xm_memwrite;
  assign mem_addr  = xm_aluresult;
  assign mem_wdata = storeData;

  // A stalled cycle becomes a bubble in MEM/WB.
  assign mw_regwrite = xm_regwrite & ~stall;
  assign mw_halt     = xm_halt & ~stall;
  assign mw_reg_dest = xm_reg_dest;
  assign mw_wdata    = xm_savepc   ? xm_newpc :
                       xm_memtoreg ? hold_q   : xm_aluresult;

  sat_counter16 uStallCnt (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (stall),
    .count_o(stall_cnt)
  );
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomized + directed bench for mem_stage_ctrl against a transaction-level reference model.
module tb_mem_stage_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        xm_regwrite, xm_memread, xm_memwrite, xm_memtoreg, xm_savepc, xm_halt;
  logic [15:0] xm_b, xm_aluresult, xm_newpc;
  logic [3:0]  xm_reg_dest, xm_source2;
  logic        wb_regwrite;
  logic [3:0]  wb_reg_dest;
  logic [15:0] wb_data;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_valid;
  logic [15:0] mem_rdata;
  logic        stall;
  logic        mw_regwrite, mw_halt;
  logic [3:0]  mw_reg_dest;
  logic [15:0] mw_wdata;
  logic [15:0] stall_cnt;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model: is an access outstanding, is its completion cycle pending, last load data.
  bit          accessOutstanding = 0;
  bit          completionPending = 0;
  logic [15:0] loadData = 16'd0;
  int          stalledCycles = 0;
  bit          expStall;

  always #5 clk = ~clk;

  mem_stage_ctrl dut (
    .clk(clk), .rst(rst),
    .xm_regwrite(xm_regwrite), .xm_memread(xm_memread), .xm_memwrite(xm_memwrite),
    .xm_memtoreg(xm_memtoreg), .xm_savepc(xm_savepc), .xm_halt(xm_halt),
    .xm_b(xm_b), .xm_aluresult(xm_aluresult), .xm_newpc(xm_newpc),
    .xm_reg_dest(xm_reg_dest), .xm_source2(xm_source2),
    .wb_regwrite(wb_regwrite), .wb_reg_dest(wb_reg_dest), .wb_data(wb_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata), .stall(stall),
    .mw_regwrite(mw_regwrite), .mw_halt(mw_halt), .mw_reg_dest(mw_reg_dest),
    .mw_wdata(mw_wdata), .stall_cnt(stall_cnt)
  );

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
  endtask

  function automatic logic [15:0] expectedStore();
`ifdef MEM_FWD_EN
    if (xm_memwrite && wb_regwrite && wb_reg_dest == xm_source2 && wb_reg_dest != 4'd0)
      return wb_data;
`endif
    return xm_b;
  endfunction

  task automatic clearInputs();
    {xm_regwrite, xm_memread, xm_memwrite, xm_memtoreg, xm_savepc, xm_halt} = '0;
    xm_b = 16'd0; xm_aluresult = 16'd0; xm_newpc = 16'd0;
    xm_reg_dest = 4'd0; xm_source2 = 4'd0;
    wb_regwrite = 1'b0; wb_reg_dest = 4'd0; wb_data = 16'd0;
    mem_valid = 1'b0; mem_rdata = 16'd0; rst = 1'b0;
  endtask

  // Called at a falling edge with inputs set: checks outputs, lets one rising edge pass,
  // advances the model, and returns at the next falling edge.
  task automatic applyStimulus(input bit doCheck);
    bit memOp, idleLike, expReq;
    logic [15:0] expData;
    #1;
    memOp    = xm_memread | xm_memwrite;
    idleLike = rst || !(accessOutstanding || completionPending);
    expStall = idleLike ? memOp : accessOutstanding;
    expReq   = idleLike ? memOp : 1'b0;
    expData  = xm_savepc ? xm_newpc : (xm_memtoreg ? loadData : xm_aluresult);
    if (doCheck) begin
      checkOutput("stall", {15'd0, stall}, {15'd0, expStall});
      checkOutput("mem_req", {15'd0, mem_req}, {15'd0, expReq});
      if (expReq) begin
        checkOutput("mem_addr", mem_addr, xm_aluresult);
        checkOutput("mem_we", {15'd0, mem_we}, {15'd0, xm_memwrite});
        checkOutput("mem_wdata", mem_wdata, expectedStore());
      end
      checkOutput("mw_regwrite", {15'd0, mw_regwrite}, {15'd0, xm_regwrite & ~expStall});
      checkOutput("mw_halt", {15'd0, mw_halt}, {15'd0, xm_halt & ~expStall});
      checkOutput("mw_reg_dest", {12'd0, mw_reg_dest}, {12'd0, xm_reg_dest});
      checkOutput("mw_wdata", mw_wdata, expData);
      checkOutput("stall_cnt", stall_cnt, 16'(stalledCycles));
    end
    @(posedge clk);
    if (rst) begin
      accessOutstanding = 0; completionPending = 0; loadData = 16'd0; stalledCycles = 0;
    end else begin
      if (expStall && stalledCycles < 65535) stalledCycles++;
      if (accessOutstanding) begin
        if (mem_valid) begin
          loadData = mem_rdata; accessOutstanding = 0; completionPending = 1;
        end
      end else if (completionPending) begin
        completionPending = 0;
      end else if (memOp) begin
        accessOutstanding = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic doReset();
    clearInputs();
    rst = 1'b1;
    applyStimulus(0);
    rst = 1'b0;
  endtask

  initial begin
    clearInputs();
    rst = 1'b1;
    @(negedge clk);
    applyStimulus(0);
    rst = 1'b0;
    #1;
    checkOutput("reset_stall_cnt", stall_cnt, 16'd0);
    checkOutput("reset_stall", {15'd0, stall}, 16'd0);
    checkOutput("reset_mw_wdata_hold", mw_wdata, 16'd0);
    @(negedge clk);

    // ALU op passes through with no added latency.
    xm_aluresult = 16'h0042; xm_regwrite = 1'b1; xm_reg_dest = 4'd7;
    #1;
    checkOutput("alu_stall", {15'd0, stall}, 16'd0);
    checkOutput("alu_wdata", mw_wdata, 16'h0042);
    checkOutput("alu_regwrite", {15'd0, mw_regwrite}, 16'd1);
    checkOutput("alu_req", {15'd0, mem_req}, 16'd0);
    applyStimulus(1);

    // Load acknowledged three cycles after the request.
    doReset();
    xm_memread = 1'b1; xm_memtoreg = 1'b1; xm_regwrite = 1'b1;
    xm_aluresult = 16'h0100; xm_reg_dest = 4'd3;
    #1;
    checkOutput("load_req", {15'd0, mem_req}, 16'd1);
    checkOutput("load_addr", mem_addr, 16'h0100);
    applyStimulus(1);
    applyStimulus(1);
    applyStimulus(1);
    mem_valid = 1'b1; mem_rdata = 16'hBEEF;
    applyStimulus(1);
    mem_valid = 1'b0; mem_rdata = 16'h0000;
    #1;
    checkOutput("load_done_stall", {15'd0, stall}, 16'd0);
    checkOutput("load_done_wdata", mw_wdata, 16'hBEEF);
    checkOutput("load_done_cnt", stall_cnt, 16'd4);
    applyStimulus(1);
    clearInputs();
    applyStimulus(1);

    // Store with a matching writeback in flight.
    xm_memwrite = 1'b1; xm_b = 16'h1234; xm_source2 = 4'd5; xm_aluresult = 16'h0200;
    wb_regwrite = 1'b1; wb_reg_dest = 4'd5; wb_data = 16'hABCD;
    #1;
    checkOutput("store_we", {15'd0, mem_we}, 16'd1);
`ifdef MEM_FWD_EN
    checkOutput("store_wdata", mem_wdata, 16'hABCD);
`else
    checkOutput("store_wdata", mem_wdata, 16'h1234);
`endif
    applyStimulus(1);
    mem_valid = 1'b1; mem_rdata = 16'h7777;
    applyStimulus(1);
    mem_valid = 1'b0;
    applyStimulus(1);
    clearInputs();
    applyStimulus(1);

    // Reset while an access is outstanding; the late acknowledge must be ignored.
    xm_memread = 1'b1; xm_memtoreg = 1'b1; xm_aluresult = 16'h0300;
    applyStimulus(1);
    rst = 1'b1;
    applyStimulus(1);
    rst = 1'b0; xm_memread = 1'b0; mem_valid = 1'b1; mem_rdata = 16'h5555;
    #1;
    checkOutput("rstbusy_stall", {15'd0, stall}, 16'd0);
    checkOutput("rstbusy_cnt", stall_cnt, 16'd0);
    checkOutput("rstbusy_hold", mw_wdata, 16'd0);
    applyStimulus(1);
    mem_valid = 1'b0; xm_memread = 1'b1;
    #1;
    checkOutput("rstbusy_no_done", {15'd0, mem_req}, 16'd1);
    applyStimulus(1);
    mem_valid = 1'b1; mem_rdata = 16'h0BAD;
    applyStimulus(1);
    clearInputs();
    applyStimulus(1);

    // Saved PC wins over memtoreg; spurious acknowledge in IDLE changes nothing.
    xm_savepc = 1'b1; xm_newpc = 16'h0020; xm_memtoreg = 1'b1; xm_regwrite = 1'b1;
    mem_valid = 1'b1; mem_rdata = 16'hDEAD;
    #1;
    checkOutput("savepc_wdata", mw_wdata, 16'h0020);
    applyStimulus(1);
    xm_savepc = 1'b0;
    #1;
    checkOutput("spurious_hold", mw_wdata, 16'h0BAD);
    applyStimulus(1);
    clearInputs();

    // Randomized traffic; EX/MEM contents stay frozen while an access is in flight.
    for (int i = 0; i < 3000; i++) begin
      if (!(accessOutstanding || completionPending)) begin
        xm_regwrite  = 1'($urandom);
        xm_memtoreg  = 1'($urandom);
        xm_savepc    = ($urandom_range(0, 7) == 0);
        xm_halt      = ($urandom_range(0, 15) == 0);
        xm_memread   = 1'b0; xm_memwrite = 1'b0;
        case ($urandom_range(0, 4))
          0: xm_memread  = 1'b1;
          1: xm_memwrite = 1'b1;
          default: ;
        endcase
        xm_b         = 16'($urandom);
        xm_aluresult = 16'($urandom);
        xm_newpc     = 16'($urandom);
        xm_reg_dest  = 4'($urandom);
        xm_source2   = 4'($urandom);
      end
      wb_regwrite = 1'($urandom);
      wb_reg_dest = ($urandom_range(0, 1) == 0) ? xm_source2 : 4'($urandom);
      wb_data     = 16'($urandom);
      mem_valid   = ($urandom_range(0, 2) == 0);
      mem_rdata   = 16'($urandom);
      rst         = ($urandom_range(0, 60) == 0);
      applyStimulus(1);
    end

    // Long unacknowledged access drives the stall counter into saturation.
    doReset();
    xm_memread = 1'b1; xm_aluresult = 16'h0400;
    for (int i = 0; i < 65540; i++) applyStimulus(0);
    #1;
    checkOutput("sat_cnt", stall_cnt, 16'hFFFF);
    applyStimulus(1);
    mem_valid = 1'b1; mem_rdata = 16'h1111;
    applyStimulus(1);
    mem_valid = 1'b0;
    applyStimulus(1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
